// File: rtl/rf_pkg.sv
// Shared register-file types: address/data widths, the r0 address and the
// write record used by the register file, writeback mux and write buffer.
package rf_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } rf_wr_t;
endpackage

// File: rtl/rf_wbuf_lookup.sv
// Bypass search over the write buffer: reports whether an address is pending
// and returns the data of the youngest pending write to it.
module rf_wbuf_lookup
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    addr_mem [DEPTH],
    input  logic [DW-1:0]    data_mem [DEPTH],
    input  logic [DEPTH-1:0] valid,
    input  logic [PW-1:0]    rd_ptr,
    input  logic [PW:0]      count,
    input  logic [AW-1:0]    q_addr,
    output logic             hit,
    output logic [DW-1:0]    data
);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (((PW+1)'(i) < count) && valid[idx] &&
                (addr_mem[idx] == q_addr) && (q_addr != AW'(REG_ZERO))) begin
                hit  = 1'b1;
                data = data_mem[idx];
            end
        end
    end

endmodule

// File: rtl/rf_write_buffer.sv
// Write buffer in front of the register file write port: queues writebacks,
// drains one per cycle onto we3/wa3/wd3 and exposes two bypass lookups.
module rf_write_buffer
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          wr_stall,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    input  logic [AW-1:0] q_addr1,
    output logic          q_hit1,
    output logic [DW-1:0] q_data1,
    input  logic [AW-1:0] q_addr2,
    output logic          q_hit2,
    output logic [DW-1:0] q_data2,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push;
    logic             pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign we3      = !empty && !wr_stall;
    assign wa3      = empty ? '0 : addr_mem[rd_ptr];
    assign wd3      = empty ? '0 : data_mem[rd_ptr];
    assign in_ready = !full || we3;
    // r0 writes complete the handshake but are silently dropped.
    assign push     = in_valid && in_ready && (in_addr != AW'(REG_ZERO));
    assign pop      = we3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // On a full push+pop the pointers coincide, so the set must win.
            if (pop)  valid[rd_ptr] <= 1'b0;
            if (push) valid[wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    rf_wbuf_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_lookup1 (
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .valid    (valid),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .q_addr   (q_addr1),
        .hit      (q_hit1),
        .data     (q_data1)
    );

    rf_wbuf_lookup #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_lookup2 (
        .addr_mem (addr_mem),
        .data_mem (data_mem),
        .valid    (valid),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .q_addr   (q_addr2),
        .hit      (q_hit2),
        .data     (q_data2)
    );

endmodule

// File: tb/tb_rf_write_buffer.sv
// Bench for rf_write_buffer: a queue model of pending writes predicts drain
// order, handshake and bypass results; a vector table adds fixed count/ready checks.
module tb_rf_write_buffer;
    import rf_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_stall;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  q_addr1;
    logic        q_hit1;
    logic [31:0] q_data1;
    logic [4:0]  q_addr2;
    logic        q_hit2;
    logic [31:0] q_data2;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int vectors = 0;
    int miscompares = 0;
    rf_wr_t sb[$];

    typedef struct {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        stall;
        logic [4:0]  qa1;
        logic [4:0]  qa2;
        logic [2:0]  exp_count;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[31];

    rf_write_buffer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_stall (wr_stall),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .q_addr1  (q_addr1),
        .q_hit1   (q_hit1),
        .q_data1  (q_data1),
        .q_addr2  (q_addr2),
        .q_hit2   (q_hit2),
        .q_data2  (q_data2),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every output against the queue model, then advances the model
    // as the coming clock edge will.
    task automatic checkOutput();
        int          n;
        logic        exp_we3;
        logic        exp_ready;
        logic [4:0]  ha;
        logic [31:0] hd;
        logic        h1, h2;
        logic [31:0] d1, d2;
        n         = sb.size();
        exp_we3   = (n != 0) && !wr_stall;
        exp_ready = (n < DEPTH) || exp_we3;
        ha = '0; hd = '0; h1 = 1'b0; h2 = 1'b0; d1 = '0; d2 = '0;
        if (n != 0) begin
            ha = sb[0].addr;
            hd = sb[0].data;
        end
        foreach (sb[i]) begin
            if (q_addr1 != 5'd0 && sb[i].addr == q_addr1) begin h1 = 1'b1; d1 = sb[i].data; end
            if (q_addr2 != 5'd0 && sb[i].addr == q_addr2) begin h2 = 1'b1; d2 = sb[i].data; end
        end
        check("count",    32'(count),    32'(n));
        check("empty",    32'(empty),    32'(n == 0));
        check("full",     32'(full),     32'(n == DEPTH));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("we3",      32'(we3),      32'(exp_we3));
        check("wa3",      32'(wa3),      32'(ha));
        check("wd3",      wd3,           hd);
        check("q_hit1",   32'(q_hit1),   32'(h1));
        check("q_data1",  q_data1,       d1);
        check("q_hit2",   32'(q_hit2),   32'(h2));
        check("q_data2",  q_data2,       d2);
        if (rst_n) begin
            if (exp_we3) void'(sb.pop_front());
            if (in_valid && exp_ready && in_addr != 5'd0)
                sb.push_back('{addr: in_addr, data: in_data});
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d,
                                 input logic s, input logic [4:0] qa1, input logic [4:0] qa2);
        @(negedge clk);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wr_stall = s;
        q_addr1  = qa1;
        q_addr2  = qa2;
        #1;
        checkOutput();
    endtask

    initial begin
        // valid addr data stall qa1 qa2 count ready
        vecs[0]  = '{1'b1, 5'd3,  32'hAAAA0001, 1'b0, 5'd3, 5'd0, 3'd0, 1'b1};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3, 5'd0, 3'd1, 1'b1};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3, 5'd0, 3'd0, 1'b1};
        vecs[3]  = '{1'b1, 5'd1,  32'h101,      1'b1, 5'd1, 5'd2, 3'd0, 1'b1};
        vecs[4]  = '{1'b1, 5'd2,  32'h102,      1'b1, 5'd1, 5'd2, 3'd1, 1'b1};
        vecs[5]  = '{1'b1, 5'd3,  32'h103,      1'b1, 5'd3, 5'd4, 3'd2, 1'b1};
        vecs[6]  = '{1'b1, 5'd4,  32'h104,      1'b1, 5'd3, 5'd4, 3'd3, 1'b1};
        vecs[7]  = '{1'b1, 5'd9,  32'h999,      1'b1, 5'd9, 5'd4, 3'd4, 1'b0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd1, 5'd9, 3'd4, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd2, 5'd4, 3'd3, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd3, 5'd4, 3'd2, 1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd4, 5'd1, 3'd1, 1'b1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd4, 5'd1, 3'd0, 1'b1};
        vecs[13] = '{1'b1, 5'd10, 32'hA0,       1'b1, 5'd0, 5'd0, 3'd0, 1'b1};
        vecs[14] = '{1'b1, 5'd11, 32'hB0,       1'b1, 5'd0, 5'd0, 3'd1, 1'b1};
        vecs[15] = '{1'b1, 5'd12, 32'hC0,       1'b1, 5'd0, 5'd0, 3'd2, 1'b1};
        vecs[16] = '{1'b1, 5'd13, 32'hD0,       1'b1, 5'd0, 5'd0, 3'd3, 1'b1};
        vecs[17] = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd10, 5'd7, 3'd4, 1'b1};
        vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd11, 3'd4, 1'b1};
        vecs[19] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd12, 3'd3, 1'b1};
        vecs[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd13, 3'd2, 1'b1};
        vecs[21] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd0, 3'd1, 1'b1};
        vecs[22] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd0, 3'd0, 1'b1};
        vecs[23] = '{1'b1, 5'd5,  32'h11,       1'b1, 5'd5, 5'd0, 3'd0, 1'b1};
        vecs[24] = '{1'b1, 5'd5,  32'h22,       1'b1, 5'd5, 5'd0, 3'd1, 1'b1};
        vecs[25] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 5'd0, 3'd2, 1'b1};
        vecs[26] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5, 5'd0, 3'd2, 1'b1};
        vecs[27] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5, 5'd0, 3'd1, 1'b1};
        vecs[28] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5, 5'd0, 3'd0, 1'b1};
        vecs[29] = '{1'b1, 5'd0,  32'hDEAD,     1'b0, 5'd0, 5'd0, 3'd0, 1'b1};
        vecs[30] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 3'd0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wr_stall = 1'b0; q_addr1 = '0; q_addr2 = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd3);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].addr, vecs[i].data,
                          vecs[i].stall, vecs[i].qa1, vecs[i].qa2);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
        end

        // Reset mid-drain with three writes still pending.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 5'(20 + i), 32'h2000 + 32'(i), 1'b1, 5'd21, 5'd22);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd21, 5'd22);
        @(negedge clk);
        rst_n = 1'b0;
        wr_stall = 1'b0;
        #1;
        check("rst_mid_empty", 32'(empty), 32'd1);
        check("rst_mid_we3",   32'(we3),   32'd0);
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_hit1",  32'(q_hit1), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd22, 5'd23);

        // Random traffic over a small address range to exercise wrap and duplicates.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
                          ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
